grid_row_loader: RTL and testbench

- Upstream of the Game-of-Life grid BRAMs. Takes the initial grid from software as 32-bit words, packs each group of 40 words into one 1280-bit row, and writes that row to the BRAM write port through mode_selector.
- Loads a full 720-row grid per start command. Flags malformed rows and the end of the load.
- Sits between the AXI-Lite register-file word feeder and the BRAM write path used by parallel_next_state.

---
 rtl/gol_pkg.sv | 20 ++
 rtl/grid_row_packer.sv | 33 +++
 rtl/grid_row_loader.sv | 184 ++++++++++++++++++
 tb/tb_grid_row_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared Game-of-Life grid constants and the row-loader state encoding.
// Optional CLEAR state exists only when GRID_ROW_LOADER_CLEAR_EN is defined.
package gol_pkg;
    localparam int X_SIZE        = 1280;
    localparam int Y_SIZE        = 720;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_ROW = X_SIZE / WORD_W;
    localparam int Y_WIDTH       = $clog2(Y_SIZE);
    localparam int CNT_W         = $clog2(WORDS_PER_ROW);

`ifdef GRID_ROW_LOADER_CLEAR_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_COLLECT, ST_WRITE, ST_DRAIN, ST_DONE, ST_CLEAR
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_COLLECT, ST_WRITE, ST_DRAIN, ST_DONE
    } loader_state_t;
`endif
endpackage

// File: rtl/grid_row_packer.sv
// Shifts 32-bit words into a row register from the MSB end and tracks the word count.
module grid_row_packer
    import gol_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_shift,
    input  logic [WORD_W-1:0]   i_word,
    output logic [X_SIZE-1:0]   o_row_next,
    output logic                o_row_full
);
    logic [X_SIZE-1:0] r_row;
    logic [CNT_W-1:0]  r_count;

    // Word 0 ends up in the top bits once all words have been shifted in.
    assign o_row_next = {r_row[X_SIZE-WORD_W-1:0], i_word};
    assign o_row_full = (r_count == CNT_W'(WORDS_PER_ROW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row   <= '0;
            r_count <= '0;
        end else begin
            if (i_shift)
                r_row <= o_row_next;
            if (i_clr)
                r_count <= '0;
            else if (i_shift)
                r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/grid_row_loader.sv
// Loads a full grid from 32-bit words into the BRAM write port, one packed row per write.
// Build option GRID_ROW_LOADER_CLEAR_EN adds a clear input that zero-fills every row.
//
// state   | meaning
// IDLE    | waiting for start
// COLLECT | accepting words of the current row
// WRITE   | one-cycle BRAM write of the packed row
// DRAIN   | discarding words of an over-long row up to tlast
// DONE    | whole grid written, load_done held
// CLEAR   | zero-filling all rows (optional)
module grid_row_loader
    import gol_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef GRID_ROW_LOADER_CLEAR_EN
    input  logic                clear,
`endif
    input  logic [WORD_W-1:0]   word_tdata,
    input  logic                word_tvalid,
    output logic                word_tready,
    input  logic                word_tlast,
    output logic [Y_WIDTH-1:0]  wr_addr,
    output logic [X_SIZE-1:0]   wr_data,
    output logic                wr_en,
    output logic                busy,
    output logic                load_done,
    output logic                err_short,
    output logic                err_long,
    output logic [Y_WIDTH:0]    rows_loaded
);
    loader_state_t     r_state, w_next;
    logic [Y_WIDTH-1:0] r_row;
    logic [Y_WIDTH:0]   r_rows_loaded;
    logic [X_SIZE-1:0]  r_wr_data;
    logic               r_err_short, r_err_long;

    logic               w_acc, w_last_row, w_row_full;
    logic [X_SIZE-1:0]  w_row_next;
    logic               w_shift, w_clr, w_capture, w_restart, w_row_adv;
    logic               w_set_short, w_set_long, w_clear_begin;

    assign w_acc      = word_tvalid & word_tready;
    assign w_last_row = (r_row == Y_WIDTH'(Y_SIZE - 1));

    grid_row_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_shift    (w_shift),
        .i_word     (word_tdata),
        .o_row_next (w_row_next),
        .o_row_full (w_row_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_shift       = 1'b0;
        w_clr         = 1'b0;
        w_capture     = 1'b0;
        w_restart     = 1'b0;
        w_row_adv     = 1'b0;
        w_set_short   = 1'b0;
        w_set_long    = 1'b0;
        w_clear_begin = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_restart = 1'b1;
                    w_clr     = 1'b1;
                    w_next    = ST_COLLECT;
                end
`ifdef GRID_ROW_LOADER_CLEAR_EN
                else if (clear) begin
                    w_clear_begin = 1'b1;
                    w_next        = ST_CLEAR;
                end
`endif
            end
            ST_COLLECT: begin
                if (start) begin
                    w_restart = 1'b1;
                    w_clr     = 1'b1;
                end else if (w_acc) begin
                    if (w_row_full) begin
                        w_clr = 1'b1;
                        if (word_tlast) begin
                            w_capture = 1'b1;
                            w_next    = ST_WRITE;
                        end else begin
                            w_set_long = 1'b1;
                            w_next     = ST_DRAIN;
                        end
                    end else if (word_tlast) begin
                        w_clr       = 1'b1;
                        w_set_short = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                w_row_adv = 1'b1;
                if (start) begin
                    w_restart = 1'b1;
                    w_clr     = 1'b1;
                    w_next    = ST_COLLECT;
                end else if (w_last_row) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (start) begin
                    w_restart = 1'b1;
                    w_clr     = 1'b1;
                    w_next    = ST_COLLECT;
                end else if (w_acc && word_tlast) begin
                    w_next = ST_COLLECT;
                end
            end
`ifdef GRID_ROW_LOADER_CLEAR_EN
            ST_CLEAR: begin
                w_row_adv = 1'b1;
                if (w_last_row)
                    w_next = ST_DONE;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    // A restart overrides the row advance of a write completing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row         <= '0;
            r_rows_loaded <= '0;
            r_wr_data     <= '0;
            r_err_short   <= 1'b0;
            r_err_long    <= 1'b0;
        end else begin
            if (w_capture)
                r_wr_data <= w_row_next;
            if (w_restart || w_clear_begin) begin
                r_row         <= '0;
                r_rows_loaded <= '0;
                r_err_short   <= 1'b0;
                r_err_long    <= 1'b0;
                if (w_clear_begin)
                    r_wr_data <= '0;
            end else begin
                if (w_row_adv) begin
                    r_rows_loaded <= r_rows_loaded + 1'b1;
                    if (!w_last_row)
                        r_row <= r_row + 1'b1;
                end
                if (w_set_short) r_err_short <= 1'b1;
                if (w_set_long)  r_err_long  <= 1'b1;
            end
        end
    end

    assign word_tready = (r_state == ST_COLLECT) || (r_state == ST_DRAIN);
    assign load_done   = (r_state == ST_DONE);
`ifdef GRID_ROW_LOADER_CLEAR_EN
    assign wr_en = (r_state == ST_WRITE) || (r_state == ST_CLEAR);
    assign busy  = word_tready || wr_en;
`else
    assign wr_en = (r_state == ST_WRITE);
    assign busy  = word_tready || wr_en;
`endif
    assign wr_addr     = r_row;
    assign wr_data     = r_wr_data;
    assign err_short   = r_err_short;
    assign err_long    = r_err_long;
    assign rows_loaded = r_rows_loaded;
endmodule

// File: tb/tb_grid_row_loader.sv
// Randomized bench for grid_row_loader: scoreboard of expected row writes built from the row/word rules.
`timescale 1ns/1ps
module tb_grid_row_loader;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [31:0]   word_tdata = '0;
    logic          word_tvalid = 1'b0;
    logic          word_tready;
    logic          word_tlast = 1'b0;
    logic [9:0]    wr_addr;
    logic [1279:0] wr_data;
    logic          wr_en, busy, load_done, err_short, err_long;
    logic [10:0]   rows_loaded;

    grid_row_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef GRID_ROW_LOADER_CLEAR_EN
        .clear       (clear),
`endif
        .word_tdata  (word_tdata),
        .word_tvalid (word_tvalid),
        .word_tready (word_tready),
        .word_tlast  (word_tlast),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .busy        (busy),
        .load_done   (load_done),
        .err_short   (err_short),
        .err_long    (err_long),
        .rows_loaded (rows_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            addr;
        logic [1279:0] data;
        int            cyc;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    exp_t m_e;
    int   m_bad;
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_wr++;
            check("tready_in_write", word_tready, 0);
            if (q.size() == 0) begin
                check("unexpected_wr_en", 1, 0);
            end else begin
                m_e = q.pop_front();
                check("wr_addr", wr_addr, m_e.addr);
                check("wr_cycle", cyc, m_e.cyc);
                check("wr_data_top", wr_data[1279:1248], m_e.data[1279:1248]);
                m_bad = 0;
                for (int k = 0; k < 40; k++)
                    if (wr_data[1279-32*k -: 32] !== m_e.data[1279-32*k -: 32]) m_bad++;
                check("wr_data_words_bad", m_bad, 0);
            end
        end
    end

    // Caller is at a falling edge; returns at the falling edge after acceptance (plus gap).
    task automatic send_word(input logic [31:0] d, input bit last, input bit push,
                             input int addr, input logic [1279:0] rowd, input int gap);
        exp_t e;
        int   n;
        word_tdata  = d;
        word_tvalid = 1'b1;
        word_tlast  = last;
        n = 0;
        while (word_tready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("tready_timeout", 0, 1);
        if (push) begin
            e.addr = addr;
            e.data = rowd;
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        word_tvalid = 1'b0;
        word_tlast  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_good_row(input int r, input bit rnd_data, input int maxgap);
        logic [31:0]   w[40];
        logic [1279:0] rowd;
        logic [9:0]    r10;
        logic [5:0]    k6;
        r10 = r[9:0];
        for (int k = 0; k < 40; k++) begin
            k6 = k[5:0];
            w[k] = rnd_data ? $urandom : {r10, k6, 16'hA5A5};
            rowd[1279-32*k -: 32] = w[k];
        end
        for (int k = 0; k < 40; k++)
            send_word(w[k], k == 39, k == 39, r, rowd, $urandom_range(maxgap, 0));
    endtask

    task automatic send_partial(input int nwords, input bit last_on_end);
        for (int k = 0; k < nwords; k++)
            send_word($urandom, last_on_end && (k == nwords - 1), 1'b0, 0, '0, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_load_done", load_done, 0);
        check("rst_err_short", err_short, 0);
        check("rst_err_long", err_long, 0);
        check("rst_rows_loaded", rows_loaded, 0);
        check("rst_tready", word_tready, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data_nz", |wr_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tready", word_tready, 0);
        check("idle_busy", busy, 0);

        // Load 1: full grid with a short row 3 and a long row 5
        pulse_start();
        check("start_busy", busy, 1);
        check("start_tready", word_tready, 1);
        for (int r = 0; r < 3; r++) send_good_row(r, r < 2, 5);
        send_partial(10, 1'b1);
        check("short_err_short", err_short, 1);
        check("short_err_long", err_long, 0);
        send_good_row(3, 1'b0, 3);
        send_good_row(4, 1'b1, 0);
        send_partial(43, 1'b1);
        check("long_err_long", err_long, 1);
        for (int r = 5; r < 720; r++) send_good_row(r, r < 12, (r < 12) ? 5 : 0);
        @(negedge clk);
        check("full_load_done", load_done, 1);
        check("full_busy", busy, 0);
        check("full_tready", word_tready, 0);
        check("full_rows_loaded", rows_loaded, 720);
        check("full_err_short_sticky", err_short, 1);
        check("full_err_long_sticky", err_long, 1);
        check("full_queue_empty", q.size(), 0);
        check("full_write_count", n_wr, 720);

        // Load 2: restart from DONE, then abort mid-row
        pulse_start();
        check("restart_load_done", load_done, 0);
        check("restart_rows_loaded", rows_loaded, 0);
        check("restart_err_short", err_short, 0);
        check("restart_err_long", err_long, 0);
        for (int r = 0; r < 50; r++) send_good_row(r, 1'b0, 0);
        send_partial(7, 1'b1);
        check("load2_err_short", err_short, 1);
        for (int r = 50; r < 100; r++) send_good_row(r, 1'b0, 0);
        @(negedge clk);
        check("load2_rows_loaded", rows_loaded, 100);
        send_partial(20, 1'b0);
        // start with a simultaneous word: the word must be dropped
        start       = 1'b1;
        word_tvalid = 1'b1;
        word_tdata  = $urandom;
        word_tlast  = 1'b0;
        @(negedge clk);
        start       = 1'b0;
        word_tvalid = 1'b0;
        check("abort_rows_loaded", rows_loaded, 0);
        check("abort_err_short", err_short, 0);
        check("abort_busy", busy, 1);
        send_good_row(0, 1'b1, 2);
        @(negedge clk);
        check("abort_err_long", err_long, 0);
        check("after_abort_rows", rows_loaded, 1);

        // Reset mid-row
        send_partial(15, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_tready", word_tready, 0);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_rows_loaded", rows_loaded, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_load_done", load_done, 0);
        check("midrst_err_short", err_short, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("final_queue_empty", q.size(), 0);
        check("final_write_count", n_wr, 821);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
